// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared 640x480@60 timing constants and coordinate width
package vga_timing_pkg;

    localparam int COORD_W = 12;

    localparam int DEFAULT_H_DISPLAY = 640;
    localparam int DEFAULT_H_FRONT   = 16;
    localparam int DEFAULT_H_SYNC    = 96;
    localparam int DEFAULT_H_BACK    = 48;
    localparam int DEFAULT_V_DISPLAY = 480;
    localparam int DEFAULT_V_FRONT   = 10;
    localparam int DEFAULT_V_SYNC    = 2;
    localparam int DEFAULT_V_BACK    = 33;
    localparam bit DEFAULT_SYNC_ACTIVE = 1'b0;
    localparam int DEFAULT_SYNC_DELAY  = 1;

    localparam int H_TOTAL = DEFAULT_H_DISPLAY + DEFAULT_H_FRONT + DEFAULT_H_SYNC + DEFAULT_H_BACK;
    localparam int V_TOTAL = DEFAULT_V_DISPLAY + DEFAULT_V_FRONT + DEFAULT_V_SYNC + DEFAULT_V_BACK;

    // True when lo <= x < lo+len.
    function automatic logic in_window(input logic [COORD_W-1:0] x, input int lo, input int len);
        return (int'(x) >= lo) && (int'(x) < lo + len);
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// rtl/sync_delay_line.sv - DEPTH x 1-bit shift register with synchronous reset value
module sync_delay_line #(
    parameter int DEPTH       = 1,
    parameter bit RESET_VALUE = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] stages;

    always_ff @(posedge clock) begin
        if (reset) begin
            stages <= {DEPTH{RESET_VALUE}};
        end else begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/vga_dtg.sv
// rtl/vga_dtg.sv - VGA display timing generator: counters, decode and delayed syncs
module vga_dtg
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY   = DEFAULT_H_DISPLAY,
    parameter int H_FRONT     = DEFAULT_H_FRONT,
    parameter int H_SYNC      = DEFAULT_H_SYNC,
    parameter int H_BACK      = DEFAULT_H_BACK,
    parameter int V_DISPLAY   = DEFAULT_V_DISPLAY,
    parameter int V_FRONT     = DEFAULT_V_FRONT,
    parameter int V_SYNC      = DEFAULT_V_SYNC,
    parameter int V_BACK      = DEFAULT_V_BACK,
    parameter bit SYNC_ACTIVE = DEFAULT_SYNC_ACTIVE,
    parameter int SYNC_DELAY  = DEFAULT_SYNC_DELAY
) (
    input  logic               clock,
    input  logic               reset,
    output logic [COORD_W-1:0] pixel_column,
    output logic [COORD_W-1:0] pixel_row,
    output logic               video_on,
    output logic               horiz_sync,
    output logic               vert_sync,
    output logic               frame_start
);

    localparam int LINE_LEN  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int FRAME_LEN = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    logic [COORD_W-1:0] h, v, h_next, v_next;
    logic video_next, frame_next, hsync_next, vsync_next;

    always_comb begin
        h_next = h + COORD_W'(1);
        v_next = v;
        if (h == COORD_W'(LINE_LEN - 1)) begin
            h_next = '0;
            v_next = (v == COORD_W'(FRAME_LEN - 1)) ? '0 : v + COORD_W'(1);
        end
    end

    // Decode the count being loaded so every registered output lines up with it.
    always_comb begin
        video_next = (h_next < COORD_W'(H_DISPLAY)) && (v_next < COORD_W'(V_DISPLAY));
        frame_next = (h_next == '0) && (v_next == '0);
        hsync_next = in_window(h_next, H_DISPLAY + H_FRONT, H_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_next = in_window(v_next, V_DISPLAY + V_FRONT, V_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            h           <= COORD_W'(LINE_LEN - 1);
            v           <= COORD_W'(FRAME_LEN - 1);
            video_on    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            h           <= h_next;
            v           <= v_next;
            video_on    <= video_next;
            frame_start <= frame_next;
        end
    end

    assign pixel_column = h;
    assign pixel_row    = v;

    // First stage is the sync output register itself; the rest are the extra delay.
    sync_delay_line #(
        .DEPTH       (SYNC_DELAY + 1),
        .RESET_VALUE (~SYNC_ACTIVE)
    ) u_hsync_delay (
        .clock (clock),
        .reset (reset),
        .din   (hsync_next),
        .dout  (horiz_sync)
    );

    sync_delay_line #(
        .DEPTH       (SYNC_DELAY + 1),
        .RESET_VALUE (~SYNC_ACTIVE)
    ) u_vsync_delay (
        .clock (clock),
        .reset (reset),
        .din   (vsync_next),
        .dout  (vert_sync)
    );

endmodule

// File: tb/tb_vga_dtg.sv
// tb/tb_vga_dtg.sv - randomized reference-model bench for vga_dtg
module tb_vga_dtg;

    logic clock;
    logic reset_a;
    logic reset_s;

    logic [11:0] col [4];
    logic [11:0] row [4];
    logic        von [4];
    logic        hs  [4];
    logic        vs  [4];
    logic        fs  [4];

    int n_cmp = 0;
    int n_bad = 0;

    // Per-instance timing: 0 default/D1, 1 default/D0, 2 default/D3, 3 small/D3.
    int ht [4] = '{800, 800, 800, 28};
    int hd [4] = '{640, 640, 640, 16};
    int hss[4] = '{656, 656, 656, 19};
    int hln[4] = '{96, 96, 96, 5};
    int vt [4] = '{525, 525, 525, 13};
    int vd [4] = '{480, 480, 480, 6};
    int vss[4] = '{490, 490, 490, 8};
    int vln[4] = '{2, 2, 2, 2};
    int dly[4] = '{1, 0, 3, 3};

    int mp [4];
    bit mvalid [4] = '{0, 0, 0, 0};
    bit mh [4][5];
    bit mv [4][5];

    initial clock = 1'b0;
    always #20 clock = ~clock;

    vga_dtg u_dut_d1 (
        .clock(clock), .reset(reset_a),
        .pixel_column(col[0]), .pixel_row(row[0]), .video_on(von[0]),
        .horiz_sync(hs[0]), .vert_sync(vs[0]), .frame_start(fs[0])
    );

    vga_dtg #(.SYNC_DELAY(0)) u_dut_d0 (
        .clock(clock), .reset(reset_a),
        .pixel_column(col[1]), .pixel_row(row[1]), .video_on(von[1]),
        .horiz_sync(hs[1]), .vert_sync(vs[1]), .frame_start(fs[1])
    );

    vga_dtg #(.SYNC_DELAY(3)) u_dut_d3 (
        .clock(clock), .reset(reset_a),
        .pixel_column(col[2]), .pixel_row(row[2]), .video_on(von[2]),
        .horiz_sync(hs[2]), .vert_sync(vs[2]), .frame_start(fs[2])
    );

    vga_dtg #(
        .H_DISPLAY(16), .H_FRONT(3), .H_SYNC(5), .H_BACK(4),
        .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .SYNC_DELAY(3)
    ) u_dut_small (
        .clock(clock), .reset(reset_s),
        .pixel_column(col[3]), .pixel_row(row[3]), .video_on(von[3]),
        .horiz_sync(hs[3]), .vert_sync(vs[3]), .frame_start(fs[3])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: position is a linear pixel index in the frame; sync history is a
    // plain list of past undelayed values, flushed to inactive by reset.
    always @(posedge clock) begin
        logic r;
        int hc, vr;
        for (int k = 0; k < 4; k++) begin
            r = (k == 3) ? reset_s : reset_a;
            if (r) begin
                mp[k] = -1;
                for (int i = 0; i < 5; i++) begin
                    mh[k][i] = 1'b1;
                    mv[k][i] = 1'b1;
                end
                mvalid[k] = 1'b1;
            end else if (mvalid[k]) begin
                mp[k] = (mp[k] + 1) % (ht[k] * vt[k]);
                hc = mp[k] % ht[k];
                vr = mp[k] / ht[k];
                for (int i = 4; i > 0; i--) begin
                    mh[k][i] = mh[k][i-1];
                    mv[k][i] = mv[k][i-1];
                end
                mh[k][0] = !(hc >= hss[k] && hc < hss[k] + hln[k]);
                mv[k][0] = !(vr >= vss[k] && vr < vss[k] + vln[k]);
            end
        end
    end

    task automatic check_all();
        int ec, er;
        for (int k = 0; k < 4; k++) begin
            if (mvalid[k]) begin
                ec = (mp[k] < 0) ? ht[k] - 1 : mp[k] % ht[k];
                er = (mp[k] < 0) ? vt[k] - 1 : mp[k] / ht[k];
                check($sformatf("u%0d col", k), 32'(col[k]), ec);
                check($sformatf("u%0d row", k), 32'(row[k]), er);
                check($sformatf("u%0d video_on", k), 32'(von[k]),
                      32'(mp[k] >= 0 && ec < hd[k] && er < vd[k]));
                check($sformatf("u%0d frame_start", k), 32'(fs[k]), 32'(mp[k] == 0));
                check($sformatf("u%0d horiz_sync", k), 32'(hs[k]), 32'(mh[k][dly[k]]));
                check($sformatf("u%0d vert_sync", k), 32'(vs[k]), 32'(mv[k][dly[k]]));
            end
        end
    endtask

    int fall_col [3] = '{-1, -1, -1};
    int low_cnt  [3] = '{0, 0, 0};
    logic prev_hs [3];
    bit forced = 0;
    bit forced_chk = 0;
    bit fs_ok = 0;
    int last_fs = 0;

    initial begin
        reset_a = 1'b1;
        reset_s = 1'b1;
        repeat (5) begin
            @(negedge clock);
            check_all();
        end
        check("rst col", 32'(col[0]), 799);
        check("rst row", 32'(row[0]), 524);
        check("rst hsync", 32'(hs[0]), 1);
        check("rst vsync", 32'(vs[0]), 1);
        check("rst video_on", 32'(von[0]), 0);
        check("rst frame_start", 32'(fs[0]), 0);
        reset_a = 1'b0;
        reset_s = 1'b0;

        @(negedge clock);
        check_all();
        check("rel col", 32'(col[0]), 0);
        check("rel row", 32'(row[0]), 0);
        check("rel video_on", 32'(von[0]), 1);
        check("rel frame_start", 32'(fs[0]), 1);
        for (int k = 0; k < 3; k++) prev_hs[k] = hs[k];

        for (int c = 1; c < 3200; c++) begin
            @(negedge clock);
            check_all();

            for (int k = 0; k < 3; k++) begin
                if (prev_hs[k] && !hs[k] && fall_col[k] < 0) fall_col[k] = int'(col[k]);
                if (c >= 800 && c < 1600 && !hs[k]) low_cnt[k]++;
                prev_hs[k] = hs[k];
            end

            if (forced_chk) begin
                check("mid rst col", 32'(col[3]), 27);
                check("mid rst row", 32'(row[3]), 12);
                check("mid rst hsync", 32'(hs[3]), 1);
                check("mid rst vsync", 32'(vs[3]), 1);
                forced_chk = 0;
            end

            if (fs[3]) begin
                if (fs_ok) check("small frame period", c - last_fs, 364);
                last_fs = c;
                fs_ok = 1;
            end

            if (reset_s) begin
                reset_s = 1'b0;
            end else if (!forced && mp[3] == 247) begin
                check("pre rst hsync", 32'(hs[3]), 0);
                check("pre rst vsync", 32'(vs[3]), 0);
                reset_s = 1'b1;
                forced = 1;
                forced_chk = 1;
                fs_ok = 0;
            end else if ($urandom_range(0, 399) == 0) begin
                reset_s = 1'b1;
                fs_ok = 0;
            end
        end

        check("hsync fall D1", fall_col[0], 657);
        check("hsync fall D0", fall_col[1], 656);
        check("hsync fall D3", fall_col[2], 659);
        check("hsync low D1", low_cnt[0], 96);
        check("hsync low D0", low_cnt[1], 96);
        check("hsync low D3", low_cnt[2], 96);
        check("mid reset reached", 32'(forced), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_dtg.md
Name: vga_dtg

Overview:
- Display timing generator for the VGA path. It sits directly upstream of the colorizer and the world/icon lookups.
- Produces the pixel coordinates, video_on, and the horizontal/vertical syncs for 640x480 at 60 Hz from a 25 MHz pixel clock.
- pixel_row/pixel_column drive the world map and icon lookup. video_on feeds the colorizer. The syncs go to the VGA connector after a configurable delay that matches the colorizer's registered output.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch, in clocks
- H_SYNC, 96, horizontal sync width, in clocks
- H_BACK, 48, horizontal back porch, in clocks
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch, in lines
- V_SYNC, 2, vertical sync width, in lines
- V_BACK, 33, vertical back porch, in lines
- SYNC_ACTIVE, 0, sync polarity when asserted (0 = active-low)
- SYNC_DELAY, 1, extra register stages on horiz_sync/vert_sync only (range 0..4)

Ports:
- clock  in  1  25 MHz pixel clock
- reset  in  1  synchronous, active-high reset
- pixel_column  out  12  horizontal count h, 0..H_TOTAL-1
- pixel_row  out  12  vertical count v, 0..V_TOTAL-1
- video_on  out  1  high when (h,v) is in the visible area
- horiz_sync  out  1  horizontal sync, delayed by SYNC_DELAY
- vert_sync  out  1  vertical sync, delayed by SYNC_DELAY
- frame_start  out  1  one-cycle pulse at (0,0)

Behaviour:
- Interface: one clock, named clock. Reset is named reset; it is synchronous and active-high. All outputs are registered.
- Derived totals:
  - H_TOTAL = sum of the four H parameters (800).
  - V_TOTAL = sum of the four V parameters (525).
- Counters:
  - h increments every clock.
  - When h = H_TOTAL-1, h wraps to 0 on the next edge and v increments.
  - When h = H_TOTAL-1 and v = V_TOTAL-1, both wrap to 0 on the same edge.
  - Counters never exceed their totals.
- Decode, aligned with the (h,v) presented in the same cycle (implement by decoding the next-state count):
  - video_on = (h < H_DISPLAY) && (v < V_DISPLAY).
  - Undelayed hsync = SYNC_ACTIVE when H_DISPLAY+H_FRONT <= h < H_DISPLAY+H_FRONT+H_SYNC (656..751), else ~SYNC_ACTIVE.
  - Undelayed vsync = SYNC_ACTIVE when V_DISPLAY+V_FRONT <= v < V_DISPLAY+V_FRONT+V_SYNC (490..491), else ~SYNC_ACTIVE.
  - vsync changes only at the h wrap edge.
  - frame_start = (h == 0) && (v == 0).
- Sync delay:
  - horiz_sync/vert_sync equal the undelayed syncs passed through a SYNC_DELAY-deep shift register.
  - Rationale: the colorizer adds 1 cycle between video_on and its VGA output, so SYNC_DELAY=1 lines the syncs up with VGA.
  - SYNC_DELAY = 0 means no extra stage; syncs are aligned with video_on.
- Reset (each clock edge with reset high):
  - h loads H_TOTAL-1 and v loads V_TOTAL-1.
  - video_on = 0, frame_start = 0.
  - All sync delay stages load ~SYNC_ACTIVE.
  - Outputs during reset: pixel_column = 799, pixel_row = 524, syncs inactive.
- After reset release:
  - First edge with reset low: counters wrap to (0,0), video_on = 1, frame_start = 1.
  - Visible output therefore begins exactly one clock after deassertion.
- Reset mid-frame: takes effect on the next edge regardless of position. Any partially shifted sync pulse is flushed to inactive.
- Invariants:
  - frame_start pulses exactly once per H_TOTAL*V_TOTAL clocks (420000).
  - horiz_sync is active for H_SYNC clocks per line.

Decomposition:
- Shared package vga_timing_pkg holds:
  - the default timing constants;
  - H_TOTAL and V_TOTAL;
  - the 12-bit coordinate width constant, also used by the colorizer/icon blocks.
- One natural sub-module: sync_delay_line, a parameterised DEPTH x 1-bit shift register with a synchronous reset value. It is instantiated once per sync.
- Counters and decode stay in vga_dtg.

Test Plan:
- Release reset after 5 cycles -> next cycle (0,0), video_on=1, frame_start=1. During reset: col=799, row=524, syncs=1.
- Run one line from (0,0):
  - video_on falls when col=640.
  - Undelayed hsync is low for cols 656..751 (96 clocks).
  - horiz_sync (SYNC_DELAY=1) goes low one cycle after col=656.
  - col=799 -> 0 with row 0 -> 1.
- Run one full frame:
  - vert_sync is low for rows 490..491 (1600 clocks), delayed by 1.
  - video_on stays 0 for rows 480..524.
  - frame_start pulses again after exactly 420000 clocks.
- Wrap corner: at (799,524) -> next edge (0,0), frame_start=1, video_on=1, both syncs inactive.
- Assert reset for 1 cycle at (700,491), with both syncs active -> syncs inactive the next cycle, counters reload (799,524), then resume at (0,0).
- SYNC_DELAY=0 and SYNC_DELAY=3 builds -> hsync fall edge at col=656 and col=659 respectively, while video_on timing is unchanged.
